// File: rtl/alu_pkg.sv
// ALU shared definitions: operand width and op codes.
// Also used by the control unit decoder.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_ADD  = 4'b1001;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;

endpackage

// File: rtl/alu_if.sv
// ALU operand/result bundle.
// The master side drives operands; the slave side returns the result.
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic [3:0]       ALUop;
  logic [WIDTH-1:0] result;

  modport master (
    output rs1,
    output rs2,
    output ALUop,
    input  result
  );

  modport slave (
    input  rs1,
    input  rs2,
    input  ALUop,
    output result
  );

endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for the ALU.
// dir=0 shifts left; dir=1 shifts right, sign-filled when arith=1.
module alu_shifter #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    shamt,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    if (!dir) begin
      result = data << shamt;
    end else if (arith) begin
      result = $signed(data) >>> shamt;
    end else begin
      result = data >> shamt;
    end
  end

endmodule

// File: rtl/alu.sv
// Execute-stage integer ALU.
// One op-select mux feeding a single result register.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic   clk,
  input logic   rst,
  alu_if.slave  bus
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] q;
  logic             dir;
  logic             arith;
  logic             lt_s;
  logic             lt_u;

  assign dir   = (bus.ALUop != ALU_SLL);
  assign arith = (bus.ALUop == ALU_SRA);
  assign lt_s  = $signed(bus.rs1) < $signed(bus.rs2);
  assign lt_u  = bus.rs1 < bus.rs2;

  // Upper rs2 bits are ignored for the shift amount.
  alu_shifter #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_shifter (
    .data   (bus.rs1),
    .shamt  (bus.rs2[SW-1:0]),
    .dir    (dir),
    .arith  (arith),
    .result (sh)
  );

  always_comb begin
    f = '0;
    unique case (1'b1)
      (bus.ALUop == ALU_ADD):  f = bus.rs1 + bus.rs2;
      (bus.ALUop == ALU_SUB):  f = bus.rs1 - bus.rs2;
      (bus.ALUop == ALU_XOR):  f = bus.rs1 ^ bus.rs2;
      (bus.ALUop == ALU_OR):   f = bus.rs1 | bus.rs2;
      (bus.ALUop == ALU_AND):  f = bus.rs1 & bus.rs2;
      (bus.ALUop == ALU_SLL):  f = sh;
      (bus.ALUop == ALU_SRL):  f = sh;
      (bus.ALUop == ALU_SRA):  f = sh;
      (bus.ALUop == ALU_SLT):  f = {{(WIDTH-1){1'b0}}, lt_s};
      (bus.ALUop == ALU_SLTU): f = {{(WIDTH-1){1'b0}}, lt_u};
      default:                 f = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= f;
    end
  end

  assign bus.result = q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu.
// Expected results queue up at drive time and are popped after each edge.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic        r;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int checks;
  int errors;
  logic [31:0] sb[$];

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst       = v.r;
    bus.rs1   = v.a;
    bus.rs2   = v.b;
    bus.ALUop = v.op;
    sb.push_back(v.exp);
  endtask

  task automatic run(input string name, input vec_t v[]);
    logic [31:0] got;
    logic [31:0] exp;
    foreach (v[i]) begin
      apply(v[i]);
      @(posedge clk);
      #1;
      got = bus.result;
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s[%0d]: result=%h expected=%h", name, i, got, exp);
      end
    end
  endtask

  task automatic test_reset;
    vec_t v[] = '{
      '{1'b1, 32'd12, 32'd18, ALU_ADD, 32'd0},
      '{1'b1, 32'd12, 32'd18, ALU_ADD, 32'd0}
    };
    run("reset", v);
  endtask

  task automatic test_add;
    vec_t v[] = '{
      '{1'b0, 32'd12, 32'd18, ALU_ADD, 32'd30},
      '{1'b0, 32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'h0000_0000}
    };
    run("add", v);
  endtask

  task automatic test_sub;
    vec_t v[] = '{
      '{1'b0, 32'd12, 32'd18, ALU_SUB, 32'hFFFF_FFFA},
      '{1'b0, 32'd18, 32'd12, ALU_SUB, 32'd6}
    };
    run("sub", v);
  endtask

  task automatic test_logic;
    vec_t v[] = '{
      '{1'b0, 32'd12, 32'd18, ALU_XOR, 32'd30},
      '{1'b0, 32'd12, 32'd18, ALU_OR,  32'd30},
      '{1'b0, 32'd12, 32'd18, ALU_AND, 32'd0},
      '{1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, ALU_XOR, 32'hFF00_0FF0}
    };
    run("logic", v);
  endtask

  task automatic test_shift;
    vec_t v[] = '{
      '{1'b0, 32'd12, 32'd2, ALU_SLL, 32'd48},
      '{1'b0, 32'd12, 32'd2, ALU_SRL, 32'd3},
      '{1'b0, 32'h8000_0000, 32'h21, ALU_SRA, 32'hC000_0000},
      '{1'b0, 32'h8000_0000, 32'h21, ALU_SRL, 32'h4000_0000},
      '{1'b0, 32'd12, 32'd0, ALU_SLL, 32'd12},
      '{1'b0, 32'h8000_0000, 32'd31, ALU_SRA, 32'hFFFF_FFFF},
      '{1'b0, 32'h8000_0000, 32'd31, ALU_SRL, 32'h0000_0001},
      '{1'b0, 32'h0000_0001, 32'd31, ALU_SLL, 32'h8000_0000},
      '{1'b0, 32'h4000_0000, 32'hFFFF_FFE1, ALU_SRA, 32'h2000_0000}
    };
    run("shift", v);
  endtask

  task automatic test_compare;
    vec_t v[] = '{
      '{1'b0, 32'hFFFF_FFFF, 32'd1, ALU_SLT,  32'd1},
      '{1'b0, 32'hFFFF_FFFF, 32'd1, ALU_SLTU, 32'd0},
      '{1'b0, 32'd1, 32'hFFFF_FFFF, ALU_SLTU, 32'd1},
      '{1'b0, 32'd5, 32'd5, ALU_SLT, 32'd0}
    };
    run("compare", v);
  endtask

  task automatic test_default;
    vec_t v[] = '{
      '{1'b0, 32'd12, 32'd18, ALU_ADD, 32'd30},
      '{1'b0, 32'd12, 32'd18, 4'b1111, 32'd0},
      '{1'b0, 32'd12, 32'd18, ALU_ADD, 32'd30},
      '{1'b0, 32'd12, 32'd18, 4'b0000, 32'd0},
      '{1'b0, 32'd12, 32'd18, 4'b1000, 32'd0}
    };
    run("default", v);
  endtask

  task automatic test_reset_priority;
    vec_t v[] = '{
      '{1'b0, 32'd7, 32'd8, ALU_ADD, 32'd15},
      '{1'b1, 32'd12, 32'd18, ALU_ADD, 32'd0},
      '{1'b0, 32'd12, 32'd18, ALU_ADD, 32'd30}
    };
    run("reset_prio", v);
  endtask

  task automatic test_mid_cycle;
    logic [31:0] got;
    logic [31:0] exp;
    vec_t v[] = '{'{1'b0, 32'd12, 32'd18, ALU_ADD, 32'd30}};
    run("mid_pre", v);
    bus.rs1   = 32'd100;
    bus.rs2   = 32'd5;
    bus.ALUop = ALU_SUB;
    sb.push_back(32'd95);
    #2;
    got = bus.result;
    checks++;
    if (got !== 32'd30) begin
      errors++;
      $display("FAIL mid_hold: result=%h expected=%h", got, 32'd30);
    end
    @(posedge clk);
    #1;
    got = bus.result;
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL mid_next: result=%h expected=%h", got, exp);
    end
  endtask

  task automatic test_back_to_back;
    vec_t v[] = '{
      '{1'b0, 32'h7FFF_FFFF, 32'd1, ALU_ADD, 32'h8000_0000},
      '{1'b0, 32'h8000_0000, 32'd1, ALU_SUB, 32'h7FFF_FFFF},
      '{1'b0, 32'h8000_0000, 32'd1, ALU_SLT, 32'd1},
      '{1'b0, 32'hAAAA_5555, 32'd4, ALU_SRA, 32'hFAAA_A555},
      '{1'b0, 32'hAAAA_5555, 32'h0000_FFFF, ALU_OR, 32'hAAAA_FFFF},
      '{1'b0, 32'hAAAA_5555, 32'h0000_FFFF, ALU_AND, 32'h0000_5555}
    };
    run("b2b", v);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.rs1   = '0;
    bus.rs2   = '0;
    bus.ALUop = '0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_compare();
    test_default();
    test_reset_priority();
    test_mid_cycle();
    test_back_to_back();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: left=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
